call_return_sequencer: RTL and testbench
========================================

// Module: call_return_sequencer
// PURPOSE
//  FSM that runs CALL_FUNCTION / RETURN_VALUE for the pamPy stack core. Drives the function-frame stack block:
//   - frame pointer enable and direction
//   - frame write enable
//   - return-value register enable
//  Pushes the return PC and data-stack TOS, jumps to the target, and on return restores PC/TOS from the frame stack.
//  Sits between the instruction decoder and the frame stack; keeps a nesting-depth counter with over/underflow detection.
// PARAMETERS
//  DATA_WIDTH  8   width of the return value word
//  ADDR_WIDTH  12  width of PC, TOS and frame-stack entries
//  MAX_DEPTH   16  max nested calls; DW = $clog2(MAX_DEPTH+1)
// PORTS
//  clk            in   1           clock, rising edge
//  reset          in   1           synchronous, active-high
//  call_req       in   1           decoder: start call (sampled only in IDLE)
//  ret_req        in   1           decoder: start return (sampled only in IDLE)
//  pc_in          in   ADDR_WIDTH  PC of the CALL instruction
//  tos_in         in   ADDR_WIDTH  current data-stack TOS pointer
//  target_addr    in   ADDR_WIDTH  function entry address
//  frame_pc_rd    in   ADDR_WIDTH  frame-stack PC read data (sync read, 1-cycle latency)
//  frame_tos_rd   in   ADDR_WIDTH  frame-stack TOS read data (same timing)
//  frame_wr_en    out  1           write both frame stacks at current pointer
//  frame_pc_wr    out  ADDR_WIDTH  return PC to push
//  frame_tos_wr   out  ADDR_WIDTH  TOS to push
//  frame_ptr_en   out  1           update frame pointer
//  frame_ptr_dir  out  1           0 = increment (push), 1 = decrement (pop)
//  ret_value_en   out  1           capture return value into return-data register
//  pc_load        out  1           1-cycle strobe: load pc_out into PC
//  pc_out         out  ADDR_WIDTH  new PC
//  tos_load       out  1           1-cycle strobe: load tos_out into TOS
//  tos_out        out  ADDR_WIDTH  restored TOS
//  busy           out  1           high in every non-IDLE state
//  done           out  1           1-cycle pulse in the final state of a call or return
//  err_overflow   out  1           1-cycle pulse: call refused, depth == MAX_DEPTH
//  err_underflow  out  1           1-cycle pulse: return refused, depth == 0
//  depth          out  DW          current nesting depth
// BEHAVIOUR
//  Reset: state IDLE, depth 0; every output 0 (registered pc_out/tos_out included).
//  States: IDLE, C_PUSH, C_INC, C_JUMP, R_DEC, R_WAIT, R_LOAD.
//  All strobes are Moore outputs of the current state.
//  IDLE, call_req (call wins if both requests high):
//   - depth < MAX_DEPTH: latch pc_in+1 (mod 2^ADDR_WIDTH), tos_in and target_addr; go to C_PUSH
//   - else: pulse err_overflow, stay IDLE, depth unchanged
//  C_PUSH: frame_wr_en=1, frame_pc_wr/frame_tos_wr = latched values -> C_INC
//  C_INC: frame_ptr_en=1, dir=0; depth+1 -> C_JUMP
//  C_JUMP: pc_load=1, pc_out=latched target, done=1 -> IDLE. Call latency: request sampled cycle 0, pc_load in cycle 3.
//  IDLE, ret_req only:
//   - depth > 0: go to R_DEC
//   - else: pulse err_underflow, stay IDLE
//  R_DEC: frame_ptr_en=1, dir=1, ret_value_en=1; depth-1 -> R_WAIT
//  R_WAIT: no strobes (frame read latency) -> R_LOAD
//  R_LOAD: pc_load=1, tos_load=1; pc_out=frame_pc_rd, tos_out=frame_tos_rd; done=1 -> IDLE
//  call_req/ret_req while busy are ignored, not queued; the decoder holds the request until done.
//  Back-to-back: a request high in the cycle after done is accepted (IDLE entered that cycle).
//  frame_wr_en and frame_ptr_en are never high in the same cycle.
//  Reset mid-operation: immediate IDLE, depth 0, strobes drop; the frame pointer has its own reset.
// TESTING
//  1 Reset, then call_req with pc_in=0x010, tos_in=0x005, target=0x200:
//    frame_wr_en in cycle 1 with data 0x011/0x005; ptr inc in cycle 2; pc_load 0x200 + done in cycle 3; depth=1.
//  2 Then ret_req, frame model returns 0x011/0x005:
//    ptr dec + ret_value_en in cycle 1; pc_load/tos_load 0x011/0x005 in cycle 3; depth=0.
//  3 ret_req at depth 0 -> err_underflow 1 cycle, no strobes, busy stays 0.
//  4 16 nested calls, then a 17th -> err_overflow, depth stays 16; then 16 returns -> depth 0, PCs restored LIFO.
//  5 call_req and ret_req together at depth 1 -> call executes, depth 2; pc_in=0xFFF pushes return PC 0x000.
//  6 Reset asserted in C_INC -> next cycle IDLE, all outputs 0; a fresh call then completes normally.

Source files
------------

// File: rtl/call_return_sequencer.sv
// Call/return sequencer for the pamPy stack core: pushes return PC/TOS onto the
// function-frame stack on CALL and restores them on RETURN, tracking nesting depth.
module call_return_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MAX_DEPTH  = 16,
    localparam int unsigned DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_req,
    input  logic                  ret_req,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] tos_in,
    input  logic [ADDR_WIDTH-1:0] target_addr,
    input  logic [ADDR_WIDTH-1:0] frame_pc_rd,
    input  logic [ADDR_WIDTH-1:0] frame_tos_rd,
    output logic                  frame_wr_en,
    output logic [ADDR_WIDTH-1:0] frame_pc_wr,
    output logic [ADDR_WIDTH-1:0] frame_tos_wr,
    output logic                  frame_ptr_en,
    output logic                  frame_ptr_dir,
    output logic                  ret_value_en,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  tos_load,
    output logic [ADDR_WIDTH-1:0] tos_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic [DW-1:0]         depth
);

    if (DATA_WIDTH == 0 || ADDR_WIDTH == 0 || MAX_DEPTH == 0) begin : g_param_check
        $fatal(1, "call_return_sequencer: widths and MAX_DEPTH must be non-zero");
    end

    localparam logic [DW-1:0] MaxDepth = DW'(MAX_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StCPush, StCInc, StCJump, StRDec, StRWait, StRLoad
    } state_e;

    state_e                state_q, state_d;
    logic [DW-1:0]         depth_q, depth_d;
    logic [ADDR_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [ADDR_WIDTH-1:0] ret_tos_q, ret_tos_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            depth_q   <= '0;
            ret_pc_q  <= '0;
            ret_tos_q <= '0;
            target_q  <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            ret_pc_q  <= ret_pc_d;
            ret_tos_q <= ret_tos_d;
            target_q  <= target_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Next-state: requests are only looked at in idle; call has priority.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        ret_pc_d  = ret_pc_q;
        ret_tos_d = ret_tos_q;
        target_d  = target_q;
        err_ovf_d = 1'b0;
        err_unf_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (call_req) begin
                    if (depth_q < MaxDepth) begin
                        ret_pc_d  = pc_in + ADDR_WIDTH'(1);
                        ret_tos_d = tos_in;
                        target_d  = target_addr;
                        state_d   = StCPush;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end else if (ret_req) begin
                    if (depth_q != '0) begin
                        state_d = StRDec;
                    end else begin
                        err_unf_d = 1'b1;
                    end
                end
            end
            StCPush: state_d = StCInc;
            StCInc: begin
                depth_d = depth_q + DW'(1);
                state_d = StCJump;
            end
            StCJump: state_d = StIdle;
            StRDec: begin
                depth_d = depth_q - DW'(1);
                state_d = StRWait;
            end
            StRWait: state_d = StRLoad;
            StRLoad: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; data buses are zero outside the state that qualifies them.
    always_comb begin
        frame_wr_en   = 1'b0;
        frame_pc_wr   = '0;
        frame_tos_wr  = '0;
        frame_ptr_en  = 1'b0;
        frame_ptr_dir = 1'b0;
        ret_value_en  = 1'b0;
        pc_load       = 1'b0;
        pc_out        = '0;
        tos_load      = 1'b0;
        tos_out       = '0;
        done          = 1'b0;
        busy          = (state_q != StIdle);
        err_overflow  = err_ovf_q;
        err_underflow = err_unf_q;
        depth         = depth_q;
        unique case (state_q)
            StCPush: begin
                frame_wr_en  = 1'b1;
                frame_pc_wr  = ret_pc_q;
                frame_tos_wr = ret_tos_q;
            end
            StCInc: frame_ptr_en = 1'b1;
            StCJump: begin
                pc_load = 1'b1;
                pc_out  = target_q;
                done    = 1'b1;
            end
            StRDec: begin
                frame_ptr_en  = 1'b1;
                frame_ptr_dir = 1'b1;
                ret_value_en  = 1'b1;
            end
            StRLoad: begin
                pc_load  = 1'b1;
                tos_load = 1'b1;
                pc_out   = frame_pc_rd;
                tos_out  = frame_tos_rd;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_call_return_sequencer.sv
// Self-checking bench for call_return_sequencer: directed vector table, hand
// sequences for reset/back-to-back, and random ops against a LIFO reference model.
module tb_call_return_sequencer;

    localparam int AW = 12;
    localparam int MD = 16;
    localparam int DWT = 5;

    localparam int KCall = 0;
    localparam int KRet  = 1;
    localparam int KOvf  = 2;
    localparam int KUnf  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          call_req, ret_req;
    logic [AW-1:0] pc_in, tos_in, target_addr;
    logic [AW-1:0] frame_pc_rd, frame_tos_rd;
    logic          frame_wr_en, frame_ptr_en, frame_ptr_dir, ret_value_en;
    logic [AW-1:0] frame_pc_wr, frame_tos_wr, pc_out, tos_out;
    logic          pc_load, tos_load, busy, done, err_overflow, err_underflow;
    logic [DWT-1:0] depth;

    call_return_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(AW), .MAX_DEPTH(MD)
    ) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
        .pc_in(pc_in), .tos_in(tos_in), .target_addr(target_addr),
        .frame_pc_rd(frame_pc_rd), .frame_tos_rd(frame_tos_rd),
        .frame_wr_en(frame_wr_en), .frame_pc_wr(frame_pc_wr), .frame_tos_wr(frame_tos_wr),
        .frame_ptr_en(frame_ptr_en), .frame_ptr_dir(frame_ptr_dir),
        .ret_value_en(ret_value_en), .pc_load(pc_load), .pc_out(pc_out),
        .tos_load(tos_load), .tos_out(tos_out), .busy(busy), .done(done),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .depth(depth)
    );

    always #5 clk = ~clk;

    // Frame-stack model: write at pointer, pointer up/down, 1-cycle sync read.
    logic [AW-1:0] fpc  [0:31];
    logic [AW-1:0] ftos [0:31];
    logic [4:0]    fp;
    always @(posedge clk) begin
        if (reset) begin
            fp <= '0;
        end else begin
            if (frame_wr_en) begin
                fpc[fp]  <= frame_pc_wr;
                ftos[fp] <= frame_tos_wr;
            end
            if (frame_ptr_en) fp <= frame_ptr_dir ? fp - 5'd1 : fp + 5'd1;
        end
        frame_pc_rd  <= fpc[fp];
        frame_tos_rd <= ftos[fp];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            call;
        bit            ret;
        logic [AW-1:0] pc;
        logic [AW-1:0] tos;
        logic [AW-1:0] tgt;
        int            kind;
        logic [AW-1:0] epc;   // pushed return PC (call) or restored PC (return)
        logic [AW-1:0] etos;
        int            edepth;
    } vec_t;

    // Reference model: the frame stack is simply a LIFO of {return PC, TOS}.
    logic [2*AW-1:0] model_q[$];

    function automatic vec_t make_vec(input bit c, input bit r, input logic [AW-1:0] pc,
                                      input logic [AW-1:0] tos, input logic [AW-1:0] tgt);
        vec_t v;
        logic [2*AW-1:0] e;
        v.call = c; v.ret = r; v.pc = pc; v.tos = tos; v.tgt = tgt;
        v.epc = '0; v.etos = '0;
        if (c) begin
            if (model_q.size() < MD) begin
                v.kind = KCall;
                v.epc  = AW'((int'(pc) + 1) % (1 << AW));
                v.etos = tos;
                model_q.push_back({v.epc, v.etos});
            end else begin
                v.kind = KOvf;
            end
        end else if (model_q.size() > 0) begin
            v.kind = KRet;
            e = model_q.pop_back();
            v.epc  = e[2*AW-1:AW];
            v.etos = e[AW-1:0];
        end else begin
            v.kind = KUnf;
        end
        v.edepth = model_q.size();
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies one request for one cycle and observes cycles 0..5.
    task automatic run_vec(input vec_t v, input string tag);
        logic [5:0] m_wr, m_inc, m_dec, m_rve, m_pcl, m_tosl, m_done, m_ovf, m_unf, m_busy;
        logic [AW-1:0] wr_pc, wr_tos, o_pc, o_tos;
        int overlap;
        {m_wr, m_inc, m_dec, m_rve, m_pcl, m_tosl, m_done, m_ovf, m_unf, m_busy} = '0;
        wr_pc = '0; wr_tos = '0; o_pc = '0; o_tos = '0; overlap = 0;
        call_req = v.call; ret_req = v.ret;
        pc_in = v.pc; tos_in = v.tos; target_addr = v.tgt;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m_wr[c]   = frame_wr_en;
            m_inc[c]  = frame_ptr_en & ~frame_ptr_dir;
            m_dec[c]  = frame_ptr_en & frame_ptr_dir;
            m_rve[c]  = ret_value_en;
            m_pcl[c]  = pc_load;
            m_tosl[c] = tos_load;
            m_done[c] = done;
            m_ovf[c]  = err_overflow;
            m_unf[c]  = err_underflow;
            m_busy[c] = busy;
            if (frame_wr_en & frame_ptr_en) overlap++;
            if (frame_wr_en) begin wr_pc = frame_pc_wr; wr_tos = frame_tos_wr; end
            if (pc_load) o_pc = pc_out;
            if (tos_load) o_tos = tos_out;
            step();
            if (c == 0) begin call_req = 1'b0; ret_req = 1'b0; end
        end
        check({tag, " wr_ptr_overlap"}, overlap, 0);
        check({tag, " depth"}, depth, v.edepth);
        case (v.kind)
            KCall: begin
                check({tag, " wr_cycle"}, m_wr, 6'b000010);
                check({tag, " wr_data"}, {wr_pc, wr_tos}, {v.epc, v.etos});
                check({tag, " inc_cycle"}, m_inc, 6'b000100);
                check({tag, " dec_rve"}, {m_dec, m_rve, m_tosl}, '0);
                check({tag, " pcload_done"}, {m_pcl, m_done}, {6'b001000, 6'b001000});
                check({tag, " pc_out"}, o_pc, v.tgt);
                check({tag, " busy"}, m_busy, 6'b001110);
                check({tag, " errs"}, {m_ovf, m_unf}, '0);
            end
            KRet: begin
                check({tag, " dec_rve_cycle"}, {m_dec, m_rve}, {6'b000010, 6'b000010});
                check({tag, " wr_inc"}, {m_wr, m_inc}, '0);
                check({tag, " loads_done"}, {m_pcl, m_tosl, m_done},
                      {6'b001000, 6'b001000, 6'b001000});
                check({tag, " restored"}, {o_pc, o_tos}, {v.epc, v.etos});
                check({tag, " busy"}, m_busy, 6'b001110);
                check({tag, " errs"}, {m_ovf, m_unf}, '0);
            end
            default: begin
                check({tag, " no_strobes"},
                      {m_wr, m_inc, m_dec, m_rve, m_pcl, m_tosl, m_done, m_busy}, '0);
                check({tag, " ovf_pulses"}, $countones(m_ovf), (v.kind == KOvf) ? 1 : 0);
                check({tag, " unf_pulses"}, $countones(m_unf), (v.kind == KUnf) ? 1 : 0);
            end
        endcase
    endtask

    function automatic logic [63:0] all_outputs();
        return {1'b0, frame_wr_en, frame_pc_wr, frame_tos_wr, frame_ptr_en, frame_ptr_dir,
                ret_value_en, pc_load, pc_out, tos_load, tos_out, busy, done,
                err_overflow, err_underflow, depth};
    endfunction

    vec_t dir_tbl[7];

    initial begin
        vec_t v;
        logic [8:0] m_pcl;
        int bias;
        dir_tbl[0] = '{1, 0, 12'h010, 12'h005, 12'h200, KCall, 12'h011, 12'h005, 1};
        dir_tbl[1] = '{0, 1, 12'h000, 12'h000, 12'h000, KRet,  12'h011, 12'h005, 0};
        dir_tbl[2] = '{0, 1, 12'h000, 12'h000, 12'h000, KUnf,  12'h000, 12'h000, 0};
        dir_tbl[3] = '{1, 0, 12'h100, 12'h007, 12'h300, KCall, 12'h101, 12'h007, 1};
        dir_tbl[4] = '{1, 1, 12'hFFF, 12'h009, 12'h400, KCall, 12'h000, 12'h009, 2};
        dir_tbl[5] = '{0, 1, 12'h000, 12'h000, 12'h000, KRet,  12'h000, 12'h009, 1};
        dir_tbl[6] = '{0, 1, 12'h000, 12'h000, 12'h000, KRet,  12'h101, 12'h007, 0};

        reset = 1'b1; call_req = 1'b0; ret_req = 1'b0;
        pc_in = '0; tos_in = '0; target_addr = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", all_outputs(), '0);
        step();

        foreach (dir_tbl[i]) run_vec(dir_tbl[i], $sformatf("dir%0d", i));

        // Fill to MAX_DEPTH, refuse one more, then unwind in LIFO order.
        for (int i = 0; i < MD; i++)
            run_vec(make_vec(1, 0, AW'(12'h100 + i * 8), AW'(i + 1), AW'(12'h800 + i)),
                    $sformatf("nest_call%0d", i));
        run_vec(make_vec(1, 0, 12'h555, 12'h055, 12'h999), "overflow");
        for (int i = 0; i < MD; i++)
            run_vec(make_vec(0, 1, '0, '0, '0), $sformatf("nest_ret%0d", i));

        // Reset while in C_INC.
        call_req = 1'b1; pc_in = 12'h0A0; tos_in = 12'h00A; target_addr = 12'h6A0;
        step(); call_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_call", all_outputs(), '0);
        step();
        model_q.delete();
        run_vec(make_vec(1, 0, 12'h0B0, 12'h00B, 12'h6B0), "after_reset");

        // Request held: second call accepted in the idle cycle right after done.
        call_req = 1'b1; pc_in = 12'h321; tos_in = 12'h021; target_addr = 12'h777;
        m_pcl = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            m_pcl[c] = pc_load;
            step();
            if (c == 6) call_req = 1'b0;
        end
        check("back_to_back_pcload", m_pcl, 9'b010001000);
        v = make_vec(1, 0, 12'h321, 12'h021, 12'h777);
        v = make_vec(1, 0, 12'h321, 12'h021, 12'h777);
        check("back_to_back_depth", depth, model_q.size());

        for (int i = 0; i < 300; i++) begin
            bias = (i < 150) ? 7 : 3;
            if ($urandom_range(0, 9) < bias)
                v = make_vec(1, $urandom_range(0, 1), AW'($urandom), AW'($urandom), AW'($urandom));
            else
                v = make_vec(0, 1, AW'($urandom), AW'($urandom), AW'($urandom));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
